// File: rtl/event_ingress_arbiter.sv
// Merges NUM_SRC event-word sources into one valid/ready stream through one-entry holding
// slots under round-robin arbitration, with per-source counters and a stretched activity flag.
module event_ingress_arbiter #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned ACT_STRETCH = 1048575
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC-1:0]                src_en,
  input  logic [NUM_SRC-1:0]                src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]     src_data,
  output logic [NUM_SRC-1:0]                src_ready,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [($clog2(NUM_SRC)|1)-1:0]    out_src,
  input  logic                              out_ready,
  input  logic                              clr_cnt,
  output logic [NUM_SRC*CNT_WIDTH-1:0]      acc_cnt,
  output logic [NUM_SRC*CNT_WIDTH-1:0]      stall_cnt,
  output logic                              activity
);

  localparam int unsigned SrcW = $clog2(NUM_SRC) | 1;
  localparam int unsigned ActW = (ACT_STRETCH > 0) ? $clog2(ACT_STRETCH + 1) : 1;
  localparam logic [SrcW-1:0] LastSrc = SrcW'(NUM_SRC - 1);

  logic [NUM_SRC-1:0]                 slot_full_q, slot_full_d;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] slot_data_q, slot_data_d;
  logic [SrcW-1:0]                    rr_ptr_q, rr_ptr_d;
  logic                               hold_q, hold_d;
  logic [SrcW-1:0]                    hold_src_q, hold_src_d;
  logic [NUM_SRC-1:0][CNT_WIDTH-1:0]  acc_q, acc_d, stall_q, stall_d;
  logic [ActW-1:0]                    act_q, act_d;

  logic [SrcW-1:0]    rr_grant, grant;
  logic               xfer;
  logic [NUM_SRC-1:0] drain, capture, ready;

  // Descending scans leave the lowest matching index; the second scan only wins when a full
  // slot exists at or above rr_ptr, otherwise the wrapped (lowest) full slot stands.
  always_comb begin
    rr_grant = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (slot_full_q[i]) rr_grant = SrcW'(i);
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (slot_full_q[i] && (SrcW'(i) >= rr_ptr_q)) rr_grant = SrcW'(i);
    end
    // A stalled offer is pinned so a later-filling slot cannot steal the output.
    grant = hold_q ? hold_src_q : rr_grant;
  end

  always_comb begin
    out_valid = |slot_full_q;
    xfer      = out_valid && out_ready;
    out_src   = grant;
    out_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == SrcW'(i)) out_data = slot_data_q[i];
    end
  end

  always_comb begin
    drain       = '0;
    capture     = '0;
    ready       = '0;
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    acc_d       = acc_q;
    stall_d     = stall_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      drain[i]       = xfer && (grant == SrcW'(i));
      ready[i]       = rst_n && src_en[i] && (!slot_full_q[i] || drain[i]);
      capture[i]     = src_valid[i] && ready[i];
      slot_full_d[i] = capture[i] || (slot_full_q[i] && !drain[i]);
      if (capture[i]) slot_data_d[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      if (clr_cnt) begin
        acc_d[i]   = '0;
        stall_d[i] = '0;
      end else begin
        if (drain[i] && (acc_q[i] != '1)) acc_d[i] = acc_q[i] + 1'b1;
        if (src_valid[i] && !ready[i] && (stall_q[i] != '1)) stall_d[i] = stall_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    hold_d     = out_valid && !out_ready;
    hold_src_d = grant;
    act_d      = act_q;
    if (xfer) begin
      rr_ptr_d = (grant == LastSrc) ? '0 : grant + 1'b1;
      act_d    = ActW'(ACT_STRETCH);
    end else if (act_q != '0) begin
      act_d = act_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full_q <= '0;
      slot_data_q <= '0;
      rr_ptr_q    <= '0;
      hold_q      <= 1'b0;
      hold_src_q  <= '0;
      acc_q       <= '0;
      stall_q     <= '0;
      act_q       <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      hold_src_q  <= hold_src_d;
      acc_q       <= acc_d;
      stall_q     <= stall_d;
      act_q       <= act_d;
    end
  end

  assign src_ready = ready;
  assign acc_cnt   = acc_q;
  assign stall_cnt = stall_q;
  assign activity  = (act_q != '0);

endmodule

// File: tb/tb_event_ingress_arbiter.sv
// Directed bench for event_ingress_arbiter: two sources, 4-bit counters, activity stretch of 10.
module tb_event_ingress_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  src_en;
  logic [1:0]  src_valid;
  logic [63:0] src_data;
  logic [1:0]  src_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [0:0]  out_src;
  logic        out_ready;
  logic        clr_cnt;
  logic [7:0]  acc_cnt;
  logic [7:0]  stall_cnt;
  logic        activity;

  int n_assert = 0;
  int n_fail   = 0;

  event_ingress_arbiter #(
    .NUM_SRC    (2),
    .DATA_WIDTH (32),
    .CNT_WIDTH  (4),
    .ACT_STRETCH(10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_en   (src_en),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready),
    .clr_cnt  (clr_cnt),
    .acc_cnt  (acc_cnt),
    .stall_cnt(stall_cnt),
    .activity (activity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    src_en    = 2'b11;
    src_valid = 2'b00;
    src_data  = '0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_activity", activity, 0);
    chk("rst_acc", acc_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_src_ready", src_ready, 2'b11);

    // Fairness: producers offer whenever the slot can take a word.
    src_data  = {32'hB000_0000, 32'hA000_0000};
    src_valid = 2'b11;
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      src_valid = src_ready;
      #1;
      chk($sformatf("fair_valid%0d", k), out_valid, 1);
      chk($sformatf("fair_src%0d", k), out_src, 32'(k % 2));
      tick();
    end
    src_valid = 2'b00;
    out_ready = 1'b0;
    #1;
    chk("fair_acc", acc_cnt, {4'd4, 4'd4});
    chk("fair_stall", stall_cnt, 0);
    chk("fair_both_full", out_valid, 1);

    // Reset with both slots holding words.
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_src_ready", src_ready, 0);
    chk("midrst_acc", acc_cnt, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_valid", out_valid, 0);
    out_ready = 1'b1;
    tick();
    chk("midrst_no_old", out_valid, 0);

    // Backpressure on source 0.
    out_ready = 1'b0;
    src_valid = 2'b01;
    src_data[31:0] = 32'hA5A5_0001;
    #1;
    chk("bp_ready_empty", src_ready[0], 1);
    tick();
    src_data[31:0] = 32'hA5A5_0002;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_data%0d", k), out_data, 32'hA5A5_0001);
      chk($sformatf("bp_ready%0d", k), src_ready[0], 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_stall", stall_cnt[3:0], 5);
    chk("bp_rel_data", out_data, 32'hA5A5_0001);
    chk("bp_rel_ready", src_ready[0], 1);
    tick();
    src_valid = 2'b00;
    #1;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_data", out_data, 32'hA5A5_0002);
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_acc", acc_cnt[3:0], 2);

    // Back-to-back refill of slot 0.
    src_valid = 2'b01;
    src_data[31:0] = 32'h1;
    tick();
    src_data[31:0] = 32'h2;
    #1;
    chk("rf_valid1", out_valid, 1);
    chk("rf_data1", out_data, 32'h1);
    tick();
    src_data[31:0] = 32'h3;
    #1;
    chk("rf_data2", out_data, 32'h2);
    tick();
    src_valid = 2'b00;
    #1;
    chk("rf_data3", out_data, 32'h3);
    tick();
    chk("rf_empty", out_valid, 0);

    // Pending word drains after its enable drops.
    out_ready = 1'b0;
    src_valid = 2'b10;
    src_data[63:32] = 32'hBEEF_0001;
    tick();
    src_en = 2'b01;
    #1;
    chk("en_ready_off", src_ready[1], 0);
    chk("en_src", out_src, 1);
    chk("en_data", out_data, 32'hBEEF_0001);
    out_ready = 1'b1;
    tick();
    src_valid = 2'b00;
    #1;
    chk("en_drained", out_valid, 0);
    chk("en_still_off", src_ready[1], 0);
    chk("en_acc1", acc_cnt[7:4], 1);
    chk("en_stall1", stall_cnt[7:4], 1);
    src_en = 2'b11;

    // Saturation after a clear.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_acc", acc_cnt, 0);
    chk("clr_stall", stall_cnt, 0);
    src_valid = 2'b01;
    for (int k = 0; k < 20; k++) begin
      src_data[31:0] = 32'(k);
      tick();
    end
    src_valid = 2'b00;
    tick();
    tick();
    chk("sat_acc0", acc_cnt[3:0], 15);
    chk("sat_empty", out_valid, 0);

    // Clear wins over a simultaneous transfer.
    out_ready = 1'b0;
    src_valid = 2'b01;
    tick();
    src_valid = 2'b00;
    out_ready = 1'b1;
    clr_cnt   = 1'b1;
    #1;
    chk("clrx_xfer", out_valid, 1);
    tick();
    clr_cnt = 1'b0;
    chk("clrx_acc", acc_cnt, 0);
    chk("clrx_empty", out_valid, 0);

    // Activity: single transfer at T.
    for (int k = 0; k < 12; k++) tick();
    chk("act_idle", activity, 0);
    src_valid = 2'b01;
    tick();
    src_valid = 2'b00;
    #1;
    chk("act_T_xfer", out_valid, 1);
    chk("act_T", activity, 0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("act1_T+%0d", k), activity, (k <= 10));
    end

    // Second transfer at T+5 stretches the flag.
    for (int k = 0; k < 12; k++) tick();
    src_valid = 2'b01;
    tick();
    src_valid = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      tick();
      src_valid = (k == 4) ? 2'b01 : 2'b00;
      chk($sformatf("act2_T+%0d", k), activity, (k <= 15));
    end
    src_valid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
